// File: rtl/ign_output_guard_pkg.sv
// ---------------------------------------------------------------------------
// ign_output_guard_pkg
// Shared definitions for the ignition output guard: the per-channel guard
// state encoding and the tick rate used to convert millisecond limits into
// clock-cycle limits (firmware and bench use the same constant).
// ---------------------------------------------------------------------------
package ign_output_guard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CHARGE   = 2'd1,
        ST_LOCKOUT  = 2'd2,
        ST_COOLDOWN = 2'd3
    } guard_state_t;

    // 2 MHz tick domain
    localparam int unsigned TICKS_PER_MS = 2000;

    function automatic int unsigned ms_to_ticks(input int unsigned ms);
        return ms * TICKS_PER_MS;
    endfunction

endpackage

// File: rtl/ign_output_guard_if.sv
// ---------------------------------------------------------------------------
// ign_output_guard_if
// Bundles the guard's request/config inputs and guarded outputs.
//   enable          : global guard enable
//   ign_req         : raw coil requests, one bit per channel (bit0 = channel a)
//   max_dwell       : max on-time in clk cycles (0 = no limit)
//   min_off         : min off-time in clk cycles (0 = no cooldown)
//   fault_clr       : per-channel single-cycle fault clear
//   ign_out         : guarded coil drive
//   fault_overdwell : sticky over-dwell flags
//   dwell_last      : packed per-channel last completed dwell length
// master = the side driving requests/config, slave = the guard itself.
// ---------------------------------------------------------------------------
interface ign_output_guard_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
);
    logic                  enable;
    logic [N_CH-1:0]       ign_req;
    logic [CNT_W-1:0]      max_dwell;
    logic [CNT_W-1:0]      min_off;
    logic [N_CH-1:0]       fault_clr;
    logic [N_CH-1:0]       ign_out;
    logic [N_CH-1:0]       fault_overdwell;
    logic [N_CH*CNT_W-1:0] dwell_last;

    modport master (
        output enable, ign_req, max_dwell, min_off, fault_clr,
        input  ign_out, fault_overdwell, dwell_last
    );

    modport slave (
        input  enable, ign_req, max_dwell, min_off, fault_clr,
        output ign_out, fault_overdwell, dwell_last
    );
endinterface

// File: rtl/ign_guard_channel.sv
// ---------------------------------------------------------------------------
// ign_guard_channel
// One guarded ignition channel: passes a coil request through with one cycle
// of latency, force-releases it after max_dwell cycles (raising a sticky
// fault), and enforces min_off idle cycles after every release.
//   clk, reset_n : clock, async active-low reset
//   enable       : low forces the channel idle (releases any dwell)
//   req          : raw coil request
//   max_dwell    : on-time limit, 0 disables
//   min_off      : cooldown length, 0 disables
//   fault_clr    : clears the sticky fault (a same-cycle set wins)
//   out          : registered coil drive
//   fault        : sticky over-dwell flag
//   dwell_last   : length of the last completed dwell (saturating)
// ---------------------------------------------------------------------------
module ign_guard_channel
    import ign_output_guard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             req,
    input  logic [CNT_W-1:0] max_dwell,
    input  logic [CNT_W-1:0] min_off,
    input  logic             fault_clr,
    output logic             out,
    output logic             fault,
    output logic [CNT_W-1:0] dwell_last
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    guard_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             out_q, out_d;
    logic             fault_q, fault_d;
    logic             fault_set;
    guard_state_t     rel_state;

    // Where a released coil goes: skip the cooldown entirely when it is zero.
    assign rel_state = (min_off == '0) ? ST_IDLE : ST_COOLDOWN;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dwell_d   = dwell_q;
        out_d     = 1'b0;
        fault_set = 1'b0;

        if (!enable) begin
            // Guard disabled: drop the coil without recording a dwell.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_d = ST_CHARGE;
                        cnt_d   = CNT_ONE;
                        out_d   = 1'b1;
                    end
                end
                ST_CHARGE: begin
                    if (!req) begin
                        state_d = rel_state;
                        dwell_d = cnt_q;
                        cnt_d   = CNT_ONE;
                    end else if ((max_dwell != '0) && (cnt_q >= max_dwell)) begin
                        // cnt counts cycles already driven high, so this
                        // yields exactly max_dwell high cycles.
                        state_d   = ST_LOCKOUT;
                        dwell_d   = cnt_q;
                        fault_set = 1'b1;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                        out_d = 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    // Stuck request: hold off until it is dropped.
                    if (!req) begin
                        state_d = rel_state;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_COOLDOWN: begin
                    if (cnt_q >= min_off) begin
                        // A request still pending starts a truncated dwell
                        // now rather than sparking late.
                        if (req) begin
                            state_d = ST_CHARGE;
                            cnt_d   = CNT_ONE;
                            out_d   = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        fault_d = fault_set | (fault_q & ~fault_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dwell_q <= '0;
            out_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            out_q   <= out_d;
            fault_q <= fault_d;
        end
    end

    assign out        = out_q;
    assign fault      = fault_q;
    assign dwell_last = dwell_q;

endmodule

// File: rtl/ign_output_guard.sv
// ---------------------------------------------------------------------------
// ign_output_guard
// Last stage before the coil pins: N_CH independent guard channels enforcing
// a maximum coil on-time and a minimum off-time, with sticky over-dwell flags.
//   clk     : system clock (2 MHz tick domain)
//   reset_n : async active-low reset
//   bus     : ign_output_guard_if slave (requests, config, guarded outputs,
//             fault flags, packed dwell_last with channel i at
//             [i*CNT_W +: CNT_W])
// ---------------------------------------------------------------------------
module ign_output_guard
    import ign_output_guard_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
) (
    input logic                clk,
    input logic                reset_n,
    ign_output_guard_if.slave  bus
);
    logic [N_CH-1:0]       out_w;
    logic [N_CH-1:0]       fault_w;
    logic [N_CH*CNT_W-1:0] dwell_w;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ign_guard_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .enable     (bus.enable),
            .req        (bus.ign_req[i]),
            .max_dwell  (bus.max_dwell),
            .min_off    (bus.min_off),
            .fault_clr  (bus.fault_clr[i]),
            .out        (out_w[i]),
            .fault      (fault_w[i]),
            .dwell_last (dwell_w[i*CNT_W +: CNT_W])
        );
    end

    assign bus.ign_out         = out_w;
    assign bus.fault_overdwell = fault_w;
    assign bus.dwell_last      = dwell_w;

endmodule
